// File: rtl/cache_req_sequencer.sv
// ---------------------------------------------------------------------------
// cache_req_sequencer
//
// Front-end stage in front of the cache. Trace commands (mode n and a 32-bit
// address) arrive over a valid/ready handshake and are buffered in a FIFO.
// Each buffered command is presented to the cache as a one-cycle valid pulse.
// After every pulse a fixed idle gap gives the cache time to finish before
// the next request goes out.
//
// Ports
//   clk         rising-edge clock
//   rstb        asynchronous active-low reset
//   in_valid    upstream command present
//   in_ready    sequencer can accept a command (FIFO not full)
//   in_n        upstream command mode
//   in_address  upstream command address
//   valid       one-cycle request strobe to the cache
//   n           mode to the cache (holds last issued value)
//   address     address to the cache (holds last issued value)
//   busy        FSM not idle or FIFO non-empty
//   fifo_level  number of buffered commands
//   issued_cnt  valid pulses issued, saturating
//   drop_cnt    illegal commands dropped, saturating
// ---------------------------------------------------------------------------
module cache_req_sequencer #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 100,
    parameter int MAX_CODE   = 9
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_n,
    input  logic [31:0]              in_address,
    output logic                     valid,
    output logic [3:0]               n,
    output logic [31:0]              address,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              issued_cnt,
    output logic [15:0]              drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [GW-1:0] GAP_INIT   = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);
    localparam logic [3:0]    MAX_N      = 4'(MAX_CODE);
    localparam logic [15:0]   CNT_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    state_t          state;
    logic [35:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [GW-1:0]   gap_cnt;
    logic            accept;
    logic            push;
    logic            drop;
    logic            pop;
    logic [3:0]      head_n;
    logic [31:0]     head_addr;

    // Ready comes from the registered level only, so a pop in the same cycle
    // never opens room for a push while full.
    assign in_ready = (fifo_level != LEVEL_FULL);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_n <= MAX_N);
    assign drop     = accept && (in_n > MAX_N);

    // Popping also looks at the registered level, so an entry pushed at an
    // edge cannot be popped at that same edge.
    assign pop = (fifo_level != '0) &&
                 ((state == IDLE) || ((state == GAP) && (gap_cnt == '0)));

    assign {head_n, head_addr} = mem[rd_ptr];
    assign busy = (state != IDLE) || (fifo_level != '0);

    // Storage array carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_n, in_address};
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is
    // a power of two.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Issue FSM. IDLE waits for data, ISSUE is the single cycle valid is
    // high, GAP counts down the mandatory quiet time. When the gap expires
    // with data waiting, the next pop goes straight back to ISSUE so pulses
    // under backlog start GAP_CYCLES+1 cycles apart.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            valid      <= 1'b0;
            n          <= '0;
            address    <= '0;
            gap_cnt    <= '0;
            issued_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        valid   <= 1'b1;
                        n       <= head_n;
                        address <= head_addr;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    valid   <= 1'b0;
                    gap_cnt <= GAP_INIT;
                    if (issued_cnt != CNT_MAX) begin
                        issued_cnt <= issued_cnt + 16'd1;
                    end
                    state <= GAP;
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (pop) begin
                            valid   <= 1'b1;
                            n       <= head_n;
                            address <= head_addr;
                            state   <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    // Illegal-code counter, saturating.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: doc/cache_req_sequencer.md
Name: cache_req_sequencer

Overview:
- Front-end stage directly upstream of the cache; replaces hand-driven trace stimulus in system runs.
- Accepts trace commands (mode n, 32-bit address) from a trace reader over a valid/ready handshake and buffers them in a FIFO.
- Presents each command to the cache as a one-cycle valid pulse on n/address.
- Enforces a fixed idle gap after every pulse so the cache completes before the next request.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, >=2.
- GAP_CYCLES, 100, valid-low cycles after each issue pulse; >=1.
- MAX_CODE, 9, highest legal n; larger codes are dropped.

Ports:
- clk  input  1  clock, rising edge
- rstb  input  1  asynchronous active-low reset
- in_valid  input  1  upstream command present
- in_ready  output  1  sequencer can accept (= !full)
- in_n  input  4  upstream command mode
- in_address  input  32  upstream command address
- valid  output  1  one-cycle request strobe to cache
- n  output  4  mode to cache
- address  output  32  address to cache
- busy  output  1  state != IDLE or FIFO non-empty
- fifo_level  output  $clog2(DEPTH)+1  entries held
- issued_cnt  output  16  valid pulses issued, saturating
- drop_cnt  output  16  illegal commands dropped, saturating

Behaviour:
- Reset is asynchronous, active-low.
  - FIFO emptied, state=IDLE, gap counter=0.
  - valid=0, n=0, address=0, issued_cnt=0, drop_cnt=0, fifo_level=0, busy=0.
  - in_ready=1 once empty, including during reset.
- Accept: transfer on a rising edge with in_valid&&in_ready.
  - in_n<=MAX_CODE: push {in_n,in_address}.
  - in_n>MAX_CODE: not stored; drop_cnt+1; fifo_level unchanged.
- in_ready is combinational !full from the registered level; no push when full, even if a pop occurs that cycle.
- Simultaneous push and pop when not full: level unchanged, both take effect.
- FSM states IDLE, ISSUE, GAP:
  - IDLE: at an edge with level>0, pop head, register n/address, valid<=1 -> ISSUE.
  - ISSUE: lasts exactly one cycle; issued_cnt+1; valid<=0, gap counter<=GAP_CYCLES-1 -> GAP.
  - GAP: decrement counter each edge. At the edge where counter==0: if level>0, pop and go to ISSUE; otherwise go to IDLE.
- Timing:
  - Pulse spacing under backlog: GAP_CYCLES+1 cycles, start to start.
  - Latency, empty and idle: command accepted at edge k; valid high in the cycle after edge k+1.
  - A push at edge k is not poppable at edge k.
- n/address hold the last issued value after valid falls, until the next issue.
- Order is strict FIFO; pointers wrap modulo DEPTH.
- Counters saturate at 16'hFFFF, no wrap.
- Reset mid-operation: everything clears immediately; pending entries are lost; no pulse after release until a new push.

Test Plan:
- Single command: reset released; push n=0, address=32'h10019D94 at edge 0 -> valid high exactly one cycle after edge 1, n=0, address=32'h10019D94; issued_cnt=1; busy=0 after GAP_CYCLES+1 more cycles.
- Backlog: push n=2/addr 0x0, n=1/addr 0x40, n=0/addr 0x80 back-to-back (GAP_CYCLES=100) -> three pulses in push order, starts exactly 101 cycles apart; issued_cnt=3.
- Full: in_valid held high with legal codes, DEPTH=8 -> 9 transfers accepted (first popped immediately), then in_ready=0 with fifo_level=8. in_ready returns 1 the cycle after the next pop.
- Illegal code: push n=4'hA while idle -> in_ready=1, drop_cnt=1, fifo_level=0, no valid pulse. Mixed stream 0,A,1 -> pulses for 0 and 1 only.
- Reset mid-gap: 3 pending, rstb low during GAP -> valid=0, fifo_level=0, counters 0 immediately; after release no pulse for 200 cycles without pushes.
- GAP_CYCLES=1, 4 commands queued -> pulses every 2 cycles; issued_cnt=4.
